// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: registered scoreboard of in-flight destinations and their
// remaining Tnew, plus a HI/LO latency counter. Produces decode-stage stall,
// the matching decode->EX bubble, one-hot forward selects, and MD suppression.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int AW         = 5,
  parameter int TW         = 3,
  parameter int MULT_LAT   = 5,
  parameter int DIV_LAT    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rs,
  input  logic [AW-1:0]         issue_rt,
  input  logic [TW-1:0]         issue_tuse_rs,
  input  logic [TW-1:0]         issue_tuse_rt,
  input  logic [AW-1:0]         issue_dst,
  input  logic [TW-1:0]         issue_tnew,
  input  logic                  issue_md_start,
  input  logic                  issue_md_div,
  input  logic                  issue_md_use,
  input  logic                  flush_req,
  output logic                  stall,
  output logic                  bubble,
  output logic [NUM_STAGES-1:0] fwd_rs_sel,
  output logic [NUM_STAGES-1:0] fwd_rt_sel,
  output logic                  md_busy,
  output logic                  dis_md
);

  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);

  localparam logic [TW-1:0] TUSE_INF  = {TW{1'b1}};
  localparam logic [TW-1:0] TNEW_ZERO = {TW{1'b0}};
  localparam logic [AW-1:0] REG_ZERO  = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  // Tnew counts down toward zero and then stays there while the entry ages.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    if (t == TNEW_ZERO) begin
      r = TNEW_ZERO;
    end else begin
      r = t - TW'(1);
    end
    return r;
  endfunction

  // $0 is hard-wired, so a source of zero never matches an in-flight writer.
  function automatic logic is_match(input logic          v,
                                    input logic [AW-1:0] d,
                                    input logic [AW-1:0] s);
    return v && (d == s) && (s != REG_ZERO);
  endfunction

  // Scoreboard storage; index 0 is EX, higher indices are older.
  logic          ent_valid_r [NUM_STAGES];
  logic [AW-1:0] ent_dst_r   [NUM_STAGES];
  logic [TW-1:0] ent_tnew_r  [NUM_STAGES];

  logic [CW-1:0] md_cnt_r;

  logic [NUM_STAGES-1:0] fwd_rs_s;
  logic [NUM_STAGES-1:0] fwd_rt_s;
  logic                  hit_rs_s;
  logic                  hit_rt_s;
  logic                  haz_rs_s;
  logic                  haz_rt_s;
  logic                  md_busy_s;
  logic                  stall_s;
  logic                  load_s;
  logic                  md_accept_s;

  // Youngest-match search: the first hit from EX outward owns the forward
  // select and alone decides the hazard, shadowing any older writer.
  always_comb begin
    fwd_rs_s = {NUM_STAGES{1'b0}};
    fwd_rt_s = {NUM_STAGES{1'b0}};
    hit_rs_s = 1'b0;
    hit_rt_s = 1'b0;
    haz_rs_s = 1'b0;
    haz_rt_s = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      fwd_rs_s[i] = !hit_rs_s && is_match(ent_valid_r[i], ent_dst_r[i], issue_rs);
      fwd_rt_s[i] = !hit_rt_s && is_match(ent_valid_r[i], ent_dst_r[i], issue_rt);
      haz_rs_s = haz_rs_s || (fwd_rs_s[i] && (issue_tuse_rs != TUSE_INF) &&
                              (ent_tnew_r[i] > issue_tuse_rs));
      haz_rt_s = haz_rt_s || (fwd_rt_s[i] && (issue_tuse_rt != TUSE_INF) &&
                              (ent_tnew_r[i] > issue_tuse_rt));
      hit_rs_s = hit_rs_s || fwd_rs_s[i];
      hit_rt_s = hit_rt_s || fwd_rt_s[i];
    end
  end

  // Issue control: a flush wins over any hazard and discards the issue.
  always_comb begin
    md_busy_s   = (md_cnt_r != CNT_ZERO);
    stall_s     = issue_valid && !flush_req &&
                  (haz_rs_s || haz_rt_s || (issue_md_use && md_busy_s));
    load_s      = issue_valid && !stall_s && !flush_req && (issue_dst != REG_ZERO);
    md_accept_s = issue_valid && issue_md_start && !stall_s && !flush_req;
  end

  // Scoreboard advance: EX takes the accepted issue (or a bubble), older
  // stages age by one with saturating Tnew, and a flush empties everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        ent_valid_r[i] <= 1'b0;
        ent_dst_r[i]   <= REG_ZERO;
        ent_tnew_r[i]  <= TNEW_ZERO;
      end
    end else begin
      if (load_s) begin
        ent_valid_r[0] <= 1'b1;
        ent_dst_r[0]   <= issue_dst;
        ent_tnew_r[0]  <= issue_tnew;
      end else begin
        ent_valid_r[0] <= 1'b0;
        ent_dst_r[0]   <= REG_ZERO;
        ent_tnew_r[0]  <= TNEW_ZERO;
      end
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (flush_req) begin
          ent_valid_r[i] <= 1'b0;
          ent_dst_r[i]   <= REG_ZERO;
          ent_tnew_r[i]  <= TNEW_ZERO;
        end else begin
          ent_valid_r[i] <= ent_valid_r[i-1];
          ent_dst_r[i]   <= ent_dst_r[i-1];
          ent_tnew_r[i]  <= sat_dec(ent_tnew_r[i-1]);
        end
      end
    end
  end

  // HI/LO latency counter: loads on an accepted start, otherwise drains to
  // zero; a flush does not stop an operation that is already running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_r <= CNT_ZERO;
    end else if (md_accept_s) begin
      md_cnt_r <= issue_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt_r != CNT_ZERO) begin
      md_cnt_r <= md_cnt_r - CW'(1);
    end else begin
      md_cnt_r <= CNT_ZERO;
    end
  end

  assign stall      = stall_s;
  assign bubble     = stall_s;
  assign fwd_rs_sel = fwd_rs_s;
  assign fwd_rt_sel = fwd_rt_s;
  assign md_busy    = md_busy_s;
  assign dis_md     = flush_req && issue_md_start;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed per-cycle vector table for the scoreboard
// and forwarding behaviour, plus hand-written MD latency and reset sequences.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic [2:0] issue_tuse_rs;
  logic [2:0] issue_tuse_rt;
  logic [4:0] issue_dst;
  logic [2:0] issue_tnew;
  logic       issue_md_start;
  logic       issue_md_div;
  logic       issue_md_use;
  logic       flush_req;
  logic       stall;
  logic       bubble;
  logic [2:0] fwd_rs_sel;
  logic [2:0] fwd_rt_sel;
  logic       md_busy;
  logic       dis_md;

  int n_cmp;
  int n_bad;

  hazard_scoreboard #(
    .NUM_STAGES(3), .AW(5), .TW(3), .MULT_LAT(5), .DIV_LAT(10)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_tuse_rs(issue_tuse_rs), .issue_tuse_rt(issue_tuse_rt),
    .issue_dst(issue_dst), .issue_tnew(issue_tnew),
    .issue_md_start(issue_md_start), .issue_md_div(issue_md_div),
    .issue_md_use(issue_md_use), .flush_req(flush_req),
    .stall(stall), .bubble(bubble), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy), .dis_md(dis_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [2:0] trs;
    logic [2:0] trt;
    logic [4:0] dst;
    logic [2:0] tnew;
    logic       mds;
    logic       mdd;
    logic       mdu;
    logic       fl;
    logic       e_stall;
    logic [2:0] e_frs;
    logic [2:0] e_frt;
    logic       e_busy;
    logic       e_dis;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  function automatic vec_t mk(input int v, input int rs, input int rt,
                              input int trs, input int trt, input int dst,
                              input int tnew, input int mds, input int mdd,
                              input int mdu, input int fl, input int e_stall,
                              input int e_frs, input int e_frt,
                              input int e_busy, input int e_dis);
    vec_t r;
    r.v = 1'(v);       r.rs = 5'(rs);     r.rt = 5'(rt);
    r.trs = 3'(trs);   r.trt = 3'(trt);   r.dst = 5'(dst);
    r.tnew = 3'(tnew); r.mds = 1'(mds);   r.mdd = 1'(mdd);
    r.mdu = 1'(mdu);   r.fl = 1'(fl);     r.e_stall = 1'(e_stall);
    r.e_frs = 3'(e_frs); r.e_frt = 3'(e_frt);
    r.e_busy = 1'(e_busy); r.e_dis = 1'(e_dis);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid    = t.v;
    issue_rs       = t.rs;
    issue_rt       = t.rt;
    issue_tuse_rs  = t.trs;
    issue_tuse_rt  = t.trt;
    issue_dst      = t.dst;
    issue_tnew     = t.tnew;
    issue_md_start = t.mds;
    issue_md_div   = t.mdd;
    issue_md_use   = t.mdu;
    flush_req      = t.fl;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Any x/z on an output turns into a mismatch via the 4-state compare.
  task automatic chk_all(input string nm, input int idx, input vec_t t);
    chk({nm, "_stall"},  idx, (stall   === t.e_stall) ? 1 : 0, 1);
    chk({nm, "_bubble"}, idx, (bubble  === t.e_stall) ? 1 : 0, 1);
    chk({nm, "_fwd_rs"}, idx, int'(fwd_rs_sel), int'(t.e_frs));
    chk({nm, "_fwd_rt"}, idx, int'(fwd_rt_sel), int'(t.e_frt));
    chk({nm, "_busy"},   idx, (md_busy === t.e_busy) ? 1 : 0, 1);
    chk({nm, "_dis_md"}, idx, (dis_md  === t.e_dis) ? 1 : 0, 1);
  endtask

  // Issue an MD start, then an HI/LO reader next cycle; count its stall cycles.
  task automatic md_seq(input logic is_div, input int lat, input int tag);
    int cnt;
    drive(mk(1, 0, 0, 7, 7, 0, 0, 1, is_div, 1, 0, 0, 0, 0, 0, 0));
    #4;
    chk("md_start_busy", tag, (md_busy === 1'b0) ? 1 : 0, 1);
    chk("md_start_stall", tag, (stall === 1'b0) ? 1 : 0, 1);
    step();
    drive(mk(1, 0, 0, 7, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #4;
    chk("md_busy_rise", tag, (md_busy === 1'b1) ? 1 : 0, 1);
    cnt = 0;
    while (stall === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #5;
    end
    chk("md_stall_len", tag, cnt, lat);
    chk("md_busy_done", tag, (md_busy === 1'b0) ? 1 : 0, 1);
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    n_cmp = 0;
    n_bad = 0;

    //             v rs rt trs trt dst tn mds mdd mdu fl | stl frs frt bsy dis
    // lw $2 (Tnew 3) then add $3,$2,$2 (Tuse 1): two stall cycles.
    vec[0]  = mk(1, 1, 0, 1, 7, 2, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[1]  = mk(1, 2, 2, 1, 1, 3, 2, 0, 0, 0, 0,  1, 1, 1, 0, 0);
    vec[2]  = mk(1, 2, 2, 1, 1, 3, 2, 0, 0, 0, 0,  1, 2, 2, 0, 0);
    vec[3]  = mk(1, 2, 2, 1, 1, 3, 2, 0, 0, 0, 0,  0, 4, 4, 0, 0);
    // addu $4 (Tnew 2), then sw base $3 / data $4 (Tuse 1 / 2): no stall.
    vec[4]  = mk(1, 0, 0, 1, 1, 4, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[5]  = mk(1, 3, 4, 1, 2, 0, 0, 0, 0, 0, 0,  0, 2, 1, 0, 0);
    // addu $6 (Tnew 2), then beq $6,$4 (Tuse 0): two stall cycles.
    vec[6]  = mk(1, 0, 0, 7, 7, 6, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[7]  = mk(1, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 4, 0, 0);
    vec[8]  = mk(1, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0);
    vec[9]  = mk(1, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4, 0, 0, 0);
    // $5 written twice; the older writer (still Tnew 2) is shadowed.
    vec[10] = mk(1, 0, 0, 7, 7, 5, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[11] = mk(1, 0, 0, 7, 7, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[12] = mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    // A $0 "writer" is never tracked; a $0 reader never forwards or stalls.
    vec[13] = mk(1, 0, 0, 7, 7, 0, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // Pending hazard plus flush: no stall, issue ($10) discarded, state empty.
    vec[15] = mk(1, 0, 0, 7, 7, 7, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[16] = mk(1, 7, 0, 1, 7, 10, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    vec[17] = mk(1, 7, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mult issued together with flush: suppressed, counter never starts.
    vec[18] = mk(1, 0, 0, 7, 7, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 1);
    vec[19] = mk(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // Hazard on a non-valid decode slot does not stall but still forwards.
    vec[20] = mk(1, 0, 0, 7, 7, 8, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec[21] = mk(0, 8, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);

    // Reset: all outputs quiet while held.
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    step();
    #3;
    z = mk(0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_all("reset", 0, z);
    step();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i]);
      #4;
      chk_all("vec", i, vec[i]);
      step();
    end
    idle();
    step();

    md_seq(1'b1, 10, 0);
    md_seq(1'b0, 5, 1);

    // Reset in the middle of a divide clears counter and scoreboard at once.
    drive(mk(1, 0, 0, 7, 7, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 0, 0, 7, 7, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(0, 9, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_pre_busy", 0, (md_busy === 1'b1) ? 1 : 0, 1);
    chk("rst_pre_fwd", 0, int'(fwd_rs_sel), 2);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 0, (md_busy === 1'b0) ? 1 : 0, 1);
    chk("rst_mid_fwd", 0, int'(fwd_rs_sel), 0);
    step();
    reset = 1'b0;
    idle();
    step();
    #3;
    chk_all("post_reset", 0, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
